hazard_ctrl: RTL

//  Pipeline hazard controller driving the CLR_E/stall side of the D->E stage register.

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the decode stage. It keeps a scoreboard of
//   in-flight register writes in E/M/W that mirrors the stage registers. The
//   scoreboard drives three things: the F/D stall, the E bubble (CLR_E), and
//   the forwarding source selects for the D and E stage operand muxes.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   flush                  synchronous flush: kills the D entry and all
//                          scoreboard entries on the next edge
//   valid_D                D instruction is valid
//   read1addr_D/2addr_D    rs / rt addresses in D
//   tuse_rs_D/tuse_rt_D    cycles until rs / rt is consumed (0 = in D)
//   use_rs_D/use_rt_D      instruction reads rs / rt
//   rfwe_D, writeaddr_D    instruction writes the RF, and its destination
//   tnew_D                 cycles from D until the result exists
//   stall_F, stall_D       hold PC / FlowReg_D
//   CLR_E                  bubble into FlowReg_E
//   fwd_rs_D, fwd_rt_D     D operand source: 0 RF, 1 E, 2 M, 3 W
//   fwd_rs_E, fwd_rt_E     E operand source: 0 carried value, 2 M, 3 W
//   stall_cnt              saturating count of stall cycles since reset

module hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_D,
  input  logic [REG_AW-1:0] read1addr_D,
  input  logic [REG_AW-1:0] read2addr_D,
  input  logic [1:0]        tuse_rs_D,
  input  logic [1:0]        tuse_rt_D,
  input  logic              use_rs_D,
  input  logic              use_rt_D,
  input  logic              rfwe_D,
  input  logic [REG_AW-1:0] writeaddr_D,
  input  logic [1:0]        tnew_D,
  output logic              stall_F,
  output logic              stall_D,
  output logic              CLR_E,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              v;
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [1:0]        tnew;
  } sb_entry_t;

  sb_entry_t         sb_e, sb_m, sb_w;
  sb_entry_t         e_nxt, m_nxt, w_nxt;
  logic [REG_AW-1:0] rs_e, rt_e;
  logic [2:0]        rs_res, rt_res;
  logic              stall;

  // An entry writes r only if it is live, writes the RF, and r is not $0.
  function automatic logic writes(input sb_entry_t s, input logic [REG_AW-1:0] r);
    return s.v && s.we && (s.addr == r) && (r != '0);
  endfunction

  function automatic logic [1:0] dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Returns {stall, fwd}. The youngest matching entry alone decides. A
  // match whose value is not ready yet gives fwd=0; stall covers that case.
  // W always holds tnew=0, so a W match can only forward.
  function automatic logic [2:0] d_lookup(input sb_entry_t e,
                                          input sb_entry_t m,
                                          input sb_entry_t w,
                                          input logic [REG_AW-1:0] r,
                                          input logic [1:0] tuse);
    logic       st;
    logic [1:0] fw;
    st = 1'b0;
    fw = 2'd0;
    if (writes(e, r)) begin
      st = (e.tnew > tuse);
      fw = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    end else if (writes(m, r)) begin
      st = (m.tnew > tuse);
      fw = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    end else if (writes(w, r)) begin
      fw = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
    end
    return {st, fw};
  endfunction

  // The E operands only look at M and W, so E forwarding is never 1.
  function automatic logic [1:0] e_lookup(input sb_entry_t m,
                                          input sb_entry_t w,
                                          input logic [REG_AW-1:0] r);
    logic [1:0] fw;
    fw = 2'd0;
    if (writes(m, r))      fw = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (writes(w, r)) fw = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
    return fw;
  endfunction

  always_comb begin
    rs_res   = d_lookup(sb_e, sb_m, sb_w, read1addr_D, tuse_rs_D);
    rt_res   = d_lookup(sb_e, sb_m, sb_w, read2addr_D, tuse_rt_D);
    stall    = valid_D && ((use_rs_D && rs_res[2]) || (use_rt_D && rt_res[2])) && !flush;
    stall_F  = stall;
    stall_D  = stall;
    CLR_E    = stall || flush;
    fwd_rs_D = rs_res[1:0];
    fwd_rt_D = rt_res[1:0];
    fwd_rs_E = sb_e.v ? e_lookup(sb_m, sb_w, rs_e) : 2'd0;
    fwd_rt_E = sb_e.v ? e_lookup(sb_m, sb_w, rt_e) : 2'd0;
  end

  // Next scoreboard contents: each entry advances one stage and its tnew
  // counts down; the new E entry mirrors what FlowReg_E captures.
  always_comb begin
    e_nxt      = '0;
    m_nxt      = sb_e;
    m_nxt.tnew = dec(sb_e.tnew);
    w_nxt      = sb_m;
    w_nxt.tnew = dec(sb_m.tnew);
    if (valid_D && !CLR_E) begin
      e_nxt.v    = 1'b1;
      e_nxt.we   = rfwe_D;
      e_nxt.addr = writeaddr_D;
      e_nxt.tnew = dec(tnew_D);
    end
    if (flush) begin
      e_nxt = '0;
      m_nxt = '0;
      w_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_e <= '0;
      sb_m <= '0;
      sb_w <= '0;
      rs_e <= '0;
      rt_e <= '0;
    end else begin
      sb_e <= e_nxt;
      sb_m <= m_nxt;
      sb_w <= w_nxt;
      // Unused sources are parked on $0 so they can never select a forward.
      rs_e <= use_rs_D ? read1addr_D : '0;
      rt_e <= use_rt_D ? read2addr_D : '0;
    end
  end

  // stall is already low during a flush, so a flush edge never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
